stepper_move_ctrl: RTL and testbench

Motion scheduler sitting ahead of the stepper phase-sequencing FSM. Accepts move commands (direction, step count) over a valid/ready handshake and emits single-cycle step pulses on a trapezoidal speed profile: accelerate, cruise, then decelerate. It drives the step/direction inputs of the phase FSM and reports busy, done and abort status to the host logic.

---
 rtl/stepper_move_ctrl.sv | 149 ++++++++++++++
 tb/tb_stepper_move_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_ctrl.sv
// Trapezoidal step scheduler ahead of the phase FSM: ramps the step interval from
// START_PERIOD down to MIN_PERIOD, cruises, then ramps back up over the same step count.
module stepper_move_ctrl #(
  parameter int unsigned PER_W        = 16,
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned START_PERIOD = 64,
  parameter int unsigned MIN_PERIOD   = 8,
  parameter int unsigned RAMP_DEC     = 4
) (
  input  logic              SYS_CLK,
  input  logic              FSM_A_RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              step_pulse,
  output logic              dir_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_left,
  output logic [PER_W-1:0]  cur_period
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_DONE} state_t;

  localparam logic [PER_W-1:0] START_P = PER_W'(START_PERIOD);
  localparam logic [PER_W-1:0] MIN_P   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W:0]   START_X = (PER_W+1)'(START_PERIOD);
  localparam logic [PER_W:0]   MIN_X   = (PER_W+1)'(MIN_PERIOD);
  localparam logic [PER_W:0]   RAMP_X  = (PER_W+1)'(RAMP_DEC);

  state_t              state_q;
  logic [PER_W-1:0]    cnt_q;
  logic [PER_W-1:0]    period_q;
  logic [STEP_W-1:0]   accel_q;
  logic [STEP_W-1:0]   steps_q;
  logic                dir_q;
  logic                done_q;
  logic                aborted_q;
  logic                busy_q;
  logic                ready_q;

  logic                expire;
  logic [STEP_W-1:0]   steps_d;
  logic [PER_W:0]      per_up;
  logic [PER_W:0]      per_dn;
  logic [PER_W-1:0]    up_sat;
  logic [PER_W-1:0]    dn_sat;

  // Ramp arithmetic carries one extra bit so neither direction can wrap before clamping.
  always_comb begin
    per_up  = {1'b0, period_q} + RAMP_X;
    per_dn  = {1'b0, period_q} - RAMP_X;
    up_sat  = (per_up > START_X) ? START_P : per_up[PER_W-1:0];
    dn_sat  = (per_dn[PER_W] || (per_dn < MIN_X)) ? MIN_P : per_dn[PER_W-1:0];
    steps_d = steps_q - STEP_W'(1);
    expire  = busy_q && (cnt_q == PER_W'(1));
  end

  // Abort wins over a coinciding expiry, so the strobe is masked in that same cycle.
  assign step_pulse = expire && !abort;
  assign cmd_ready  = ready_q;
  assign dir_out    = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_q;
  assign cur_period = period_q;

  always_ff @(posedge SYS_CLK or posedge FSM_A_RESET) begin
    if (FSM_A_RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= START_P;
      period_q  <= START_P;
      accel_q   <= '0;
      steps_q   <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dir_q     <= cmd_dir;
            steps_q   <= cmd_steps;
            cnt_q     <= START_P;
            period_q  <= START_P;
            accel_q   <= '0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b0;
            if (cmd_steps == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ACCEL;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ACCEL, S_CRUISE, S_DECEL: begin
          if (abort) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (expire) begin
            steps_q <= steps_d;
            if (steps_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              cnt_q   <= period_q;
            end else if (steps_d <= accel_q) begin
              // Remaining steps now match the ramp-up length: mirror it on the way down.
              state_q  <= S_DECEL;
              period_q <= up_sat;
              cnt_q    <= up_sat;
            end else if (state_q == S_ACCEL) begin
              period_q <= dn_sat;
              cnt_q    <= dn_sat;
              accel_q  <= accel_q + STEP_W'(1);
              if (dn_sat == MIN_P) state_q <= S_CRUISE;
            end else begin
              cnt_q <= period_q;
            end
          end else begin
            cnt_q <= cnt_q - PER_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl: expected pulse intervals are queued per command
// and popped as each step_pulse appears.
module tb_stepper_move_ctrl;

  localparam int PER_W  = 16;
  localparam int STEP_W = 16;

  logic              SYS_CLK = 1'b0;
  logic              FSM_A_RESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              abort;
  logic              step_pulse;
  logic              dir_out;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [STEP_W-1:0] steps_left;
  logic [PER_W-1:0]  cur_period;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;
  int exp_q[$];

  stepper_move_ctrl #(
    .PER_W(16), .STEP_W(16), .START_PERIOD(64), .MIN_PERIOD(8), .RAMP_DEC(4)
  ) dut (
    .SYS_CLK(SYS_CLK), .FSM_A_RESET(FSM_A_RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .abort(abort), .step_pulse(step_pulse), .dir_out(dir_out), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left), .cur_period(cur_period)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
    t++;
  endtask

  task automatic accept(input int nsteps, input logic dir);
    cmd_valid = 1'b1;
    cmd_steps = STEP_W'(nsteps);
    cmd_dir   = dir;
    tick();
    cmd_valid = 1'b0;
    t = 1;
  endtask

  // Runs one full move; the cycle holding cmd_valid&cmd_ready is cycle 0.
  task automatic run_move(input int nsteps, input logic dir);
    int last;
    int pulses;
    int e;
    bit seen_done;
    last = 0; pulses = 0; seen_done = 0;
    accept(nsteps, dir);
    while (!seen_done && t < 20000) begin
      if (t == 2) begin
        chk("busy_in_move", int'(busy), 1);
        chk("ready_in_move", int'(cmd_ready), 0);
      end
      if (step_pulse) begin
        if (exp_q.size() == 0) begin
          chk("extra_pulse", pulses + 1, nsteps);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_interval", t - last, e);
          chk("cur_period", int'(cur_period), e);
          chk("steps_left_at_pulse", int'(steps_left), nsteps - pulses);
        end
        last = t;
        pulses++;
      end
      if (done) seen_done = 1;
      else tick();
    end
    chk("done_seen", int'(seen_done), 1);
    chk("pulse_count", pulses, nsteps);
    chk("done_latency", t - last, 1);
    chk("aborted_clear", int'(aborted), 0);
    chk("dir_out", int'(dir_out), int'(dir));
    chk("busy_at_done", int'(busy), 0);
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("ready_after_done", int'(cmd_ready), 1);
    exp_q.delete();
  endtask

  initial begin
    int pulses;
    int tp;
    FSM_A_RESET = 1'b1;
    cmd_valid   = 1'b0;
    cmd_dir     = 1'b0;
    cmd_steps   = '0;
    abort       = 1'b0;
    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_pulse", int'(step_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_dir", int'(dir_out), 0);
    chk("rst_steps_left", int'(steps_left), 0);
    chk("rst_period", int'(cur_period), 64);
    tick(); tick();
    FSM_A_RESET = 1'b0;
    tick();

    // Single step, CW.
    exp_q.push_back(64);
    run_move(1, 1'b1);

    // Four steps: two accel intervals, then one decel.
    exp_q.push_back(64); exp_q.push_back(60); exp_q.push_back(56); exp_q.push_back(60);
    run_move(4, 1'b0);

    // Full trapezoid: 14 ramp steps down to 8, cruise, mirrored ramp up.
    for (int k = 1; k <= 100; k++) begin
      if (k <= 14)      exp_q.push_back(64 - 4 * (k - 1));
      else if (k <= 86) exp_q.push_back(8);
      else              exp_q.push_back(8 + 4 * (k - 86));
    end
    run_move(100, 1'b1);

    // Reset in the middle of a long move.
    accept(100, 1'b1);
    while (t < 300) tick();
    FSM_A_RESET = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pulse", int'(step_pulse), 0);
    chk("midrst_steps_left", int'(steps_left), 0);
    chk("midrst_period", int'(cur_period), 64);
    chk("midrst_ready", int'(cmd_ready), 1);
    tick();
    FSM_A_RESET = 1'b0;
    tick();
    exp_q.push_back(64);
    run_move(1, 1'b1);

    // Abort in cruise exactly on an expiry cycle; stray command mid-move.
    accept(100, 1'b0);
    pulses = 0; tp = 0;
    while (pulses < 20 && t < 5000) begin
      if (step_pulse) begin
        pulses++;
        tp = t;
      end
      if (pulses < 20) tick();
    end
    chk("abort_setup_pulses", pulses, 20);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) begin
        cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_dir = 1'b1;
      end
      if (i == 3) begin
        chk("ready_low_cruise", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
      end
    end
    chk("pre_abort_expiry", int'(step_pulse), 1);
    abort = 1'b1;
    #1;
    chk("abort_masks_pulse", int'(step_pulse), 0);
    chk("abort_steps_left", int'(steps_left), 80);
    tick();
    abort = 1'b0;
    chk("abort_done", int'(done), 1);
    chk("abort_flag", int'(aborted), 1);
    chk("abort_steps_frozen", int'(steps_left), 80);
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_pulse", int'(step_pulse), 0);
    chk("abort_dir_kept", int'(dir_out), 0);
    tick();
    chk("abort_done_one_cycle", int'(done), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_flag_held", int'(aborted), 1);

    // Zero-step move: done straight away, aborted cleared by the accept.
    accept(0, 1'b1);
    chk("zero_done", int'(done), 1);
    chk("zero_aborted", int'(aborted), 0);
    chk("zero_pulse", int'(step_pulse), 0);
    chk("zero_busy", int'(busy), 0);
    chk("zero_dir", int'(dir_out), 1);
    tick();
    chk("zero_done_clear", int'(done), 0);
    chk("zero_ready", int'(cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
